decode_stage: RTL
=================

Name: decode_stage

Overview:
- RV32I decode stage, directly downstream of the fetch stage; consumes its registered pc_out/instr_out.
- Decodes the instruction, reads a 32x32 register file (x0 hardwired to 0, writeback bypass) and generates immediates and control.
- Detects load-use hazards, drives stall_f back to fetch, and registers all results into the D/E pipeline register.

Parameters:
- XLEN, 32, datapath width (word_t).
- NREGS, 32, register file depth; index width log2(NREGS)=5.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- valid_in  in  1  pc_in/instr_in hold a real instruction (low for the first cycle after reset).
- pc_in  in  32  pc from fetch.
- instr_in  in  32  instruction from fetch.
- branch_taken  in  1  redirect from execute; flushes decode.
- wb_en  in  1  register-file write enable.
- wb_rd  in  5  write index.
- wb_data  in  32  write data.
- stall_f  out  1  combinational; hold fetch this cycle.
- valid_d  out  1  D/E register holds a real instruction.
- pc_d, rs1_val, rs2_val, imm  out  32 each  registered.
- rs1, rs2, rd  out  5 each  registered indices.
- alu_op  out  5  0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and; 16-23 reserved for M.
- funct3  out  3  registered.
- ctrl  out  10  {reg_write, mem_read, mem_write, branch, jal, jalr, alu_src_imm, lui, auipc, illegal}.

Behaviour:
- Reset:
  - valid_d=0, ctrl=0, all other outputs 0.
  - Hold register is cleared; stall_f=0.
  - Register file contents are not reset.
- Latency: one cycle. An instruction presented at edge N appears on the *_d outputs after edge N+1.
- Source select: if hold_valid, use hold_pc/hold_instr; otherwise use pc_in/instr_in with valid_in.
- Decode:
  - Opcodes 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011 and 0001111 (fence, treated as nop).
  - Any other opcode, or a bad funct3/funct7 combination, sets illegal=1 and forces reg_write, mem_read and mem_write to 0.
- Immediates are sign-extended from bit 31, per the I/S/B/U/J formats. R-type imm=0.
- Register read:
  - Index 0 reads 0.
  - If wb_en && wb_rd==rsX && wb_rd!=0, the read returns wb_data in the same cycle (bypass).
  - Write occurs at posedge when wb_en && wb_rd!=0.
- Load-use hazard: stall_f=1 when all of the following hold:
  - the current source is valid;
  - valid_d && mem_read_d;
  - rd_d!=0;
  - rd_d matches a source register the current instruction actually uses (rs1 for all except lui/auipc/jal; rs2 only for R, S and B types).
- On stall: capture the current source into the hold register (hold_valid=1) and load a bubble into the D/E register (valid_d=0, ctrl=0). The next cycle decodes from the hold register.
- Priority at each edge: rst > branch_taken > stall > normal.
  - branch_taken: valid_d<=0, ctrl<=0, hold_valid<=0. Under branch_taken, stall_f=0.
  - Normal: D/E register<=decoded source with valid_d<=source valid; hold_valid<=0.
- A bubble or invalid source never asserts stall_f, and never produces a nonzero ctrl on the outputs.

Optional Feature:
- DECODE_RV32M_EN defined: opcode 0110011 with funct7=0000001 decodes to alu_op 16+funct3 (mul, mulh, mulhsu, mulhu, div, divu, rem, remu) with reg_write=1.
- Undefined: that encoding is illegal (illegal=1, reg_write=0).

Test Plan:
- Reset, then valid_in=1, pc_in=0x0, instr_in=0x00500093 (addi x1,x0,5):
  - next cycle valid_d=1, rd=1, rs1=0, imm=5, alu_op=0, reg_write=1, alu_src_imm=1.
- Bypass: wb_en=1, wb_rd=2, wb_data=0xDEADBEEF in the same cycle as instr 0x001101B3 (add x3,x2,x1) -> rs1_val=0xDEADBEEF.
- Load-use: decode 0x0000A103 (lw x2,0(x1)), then 0x001101B3:
  - stall_f=1 for exactly one cycle;
  - valid_d=0 bubble;
  - the held add then issues with valid_d=1 and pc_d unchanged.
- Flush priority: load-use stall pending and branch_taken=1 in the same cycle -> stall_f=0, valid_d=0 next cycle, hold cleared.
- Illegal: instr 0xFFFFFFFF -> illegal=1, reg_write=0, mem_read=0, mem_write=0.
- 0x027302B3 (mul x5,x6,x7):
  - with DECODE_RV32M_EN: alu_op=16, reg_write=1;
  - without it: illegal=1, reg_write=0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: decode, register-file read with writeback bypass, immediate
// generation, load-use stall and the D/E pipeline register. Define DECODE_RV32M_EN to accept RV32M.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  input  logic            branch_taken,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_f,
  output logic            valid_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [4:0]      alu_op,
  output logic [2:0]      funct3,
  output logic [9:0]      ctrl
);

  typedef logic [XLEN-1:0] word_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;

  // ctrl bit positions
  localparam int C_MEM_READ = 8;

  // Hold register: the instruction that stalled, replayed the following cycle
  logic        r_hold_valid;
  word_t       r_hold_pc;
  logic [31:0] r_hold_instr;

  // D/E pipeline register
  logic        r_valid_d;
  word_t       r_pc_d;
  word_t       r_rs1_val;
  word_t       r_rs2_val;
  word_t       r_imm;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [4:0]  r_alu_op;
  logic [2:0]  r_funct3;
  logic [9:0]  r_ctrl;

  word_t       r_rf [NREGS];

  logic        w_src_valid;
  word_t       w_src_pc;
  logic [31:0] w_src_instr;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;

  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  logic        w_rw, w_mr, w_mw, w_br, w_jal, w_jalr, w_asi, w_lui, w_auipc, w_bad;
  logic [4:0]  w_alu_op;
  logic [31:0] w_imm32;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic [9:0]  w_ctrl;
  logic [4:0]  w_alu_final;

  word_t       w_rs1_val;
  word_t       w_rs2_val;
  logic        w_ld_hit;

  assign w_src_valid = r_hold_valid | valid_in;
  assign w_src_pc    = r_hold_valid ? r_hold_pc    : pc_in;
  assign w_src_instr = r_hold_valid ? r_hold_instr : instr_in;

  assign w_opcode = w_src_instr[6:0];
  assign w_rd     = w_src_instr[11:7];
  assign w_f3     = w_src_instr[14:12];
  assign w_rs1    = w_src_instr[19:15];
  assign w_rs2    = w_src_instr[24:20];
  assign w_f7     = w_src_instr[31:25];

  assign w_imm_i = {{20{w_src_instr[31]}}, w_src_instr[31:20]};
  assign w_imm_s = {{20{w_src_instr[31]}}, w_src_instr[31:25], w_src_instr[11:7]};
  assign w_imm_b = {{19{w_src_instr[31]}}, w_src_instr[31], w_src_instr[7],
                    w_src_instr[30:25], w_src_instr[11:8], 1'b0};
  assign w_imm_u = {w_src_instr[31:12], 12'b0};
  assign w_imm_j = {{11{w_src_instr[31]}}, w_src_instr[31], w_src_instr[19:12],
                    w_src_instr[20], w_src_instr[30:21], 1'b0};

  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  base_alu = ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

  always_comb begin
    w_rw       = 1'b0;
    w_mr       = 1'b0;
    w_mw       = 1'b0;
    w_br       = 1'b0;
    w_jal      = 1'b0;
    w_jalr     = 1'b0;
    w_asi      = 1'b0;
    w_lui      = 1'b0;
    w_auipc    = 1'b0;
    w_bad      = 1'b0;
    w_alu_op   = ALU_ADD;
    w_imm32    = '0;
    w_uses_rs1 = 1'b1;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      OP_LUI: begin
        w_rw = 1'b1; w_asi = 1'b1; w_lui = 1'b1;
        w_imm32 = w_imm_u; w_uses_rs1 = 1'b0;
      end
      OP_AUIPC: begin
        w_rw = 1'b1; w_asi = 1'b1; w_auipc = 1'b1;
        w_imm32 = w_imm_u; w_uses_rs1 = 1'b0;
      end
      OP_JAL: begin
        w_rw = 1'b1; w_jal = 1'b1;
        w_imm32 = w_imm_j; w_uses_rs1 = 1'b0;
      end
      OP_JALR: begin
        w_rw = 1'b1; w_jalr = 1'b1; w_asi = 1'b1;
        w_imm32 = w_imm_i;
        w_bad = (w_f3 != 3'b000);
      end
      OP_BRANCH: begin
        w_br = 1'b1; w_imm32 = w_imm_b; w_uses_rs2 = 1'b1;
        case (w_f3)
          3'b000, 3'b001: w_alu_op = ALU_SUB;
          3'b100, 3'b101: w_alu_op = ALU_SLT;
          3'b110, 3'b111: w_alu_op = ALU_SLTU;
          default:        w_bad    = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_rw = 1'b1; w_mr = 1'b1; w_asi = 1'b1;
        w_imm32 = w_imm_i;
        w_bad = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OP_STORE: begin
        w_mw = 1'b1; w_asi = 1'b1; w_uses_rs2 = 1'b1;
        w_imm32 = w_imm_s;
        w_bad = (w_f3 > 3'b010);
      end
      OP_IMM: begin
        w_rw = 1'b1; w_asi = 1'b1;
        w_imm32 = w_imm_i;
        w_alu_op = base_alu(w_f3);
        // Shift-immediates carry the shift kind in the upper immediate bits
        if (w_f3 == 3'b001) begin
          w_bad = (w_f7 != 7'b0000000);
        end else if (w_f3 == 3'b101) begin
          if (w_f7 == 7'b0100000) w_alu_op = ALU_SRA;
          else if (w_f7 != 7'b0000000) w_bad = 1'b1;
        end
      end
      OP_REG: begin
        w_rw = 1'b1; w_uses_rs2 = 1'b1;
        case (w_f7)
          7'b0000000: w_alu_op = base_alu(w_f3);
          7'b0100000: begin
            if (w_f3 == 3'b000)      w_alu_op = ALU_SUB;
            else if (w_f3 == 3'b101) w_alu_op = ALU_SRA;
            else                     w_bad    = 1'b1;
          end
`ifdef DECODE_RV32M_EN
          7'b0000001: w_alu_op = 5'd16 + {2'b00, w_f3};
`endif
          default: w_bad = 1'b1;
        endcase
      end
      OP_FENCE: begin
        w_uses_rs1 = 1'b1;
      end
      default: w_bad = 1'b1;
    endcase
  end

  // An illegal instruction must not touch architectural state or memory
  assign w_ctrl      = w_bad ? 10'b00_0000_0001
                             : {w_rw, w_mr, w_mw, w_br, w_jal, w_jalr, w_asi, w_lui, w_auipc, 1'b0};
  assign w_alu_final = w_bad ? ALU_ADD : w_alu_op;

  always_ff @(posedge clk) begin
    if (wb_en && (wb_rd != 5'd0)) r_rf[wb_rd] <= wb_data;
  end

  always_comb begin
    w_rs1_val = '0;
    if (w_rs1 != 5'd0) w_rs1_val = (wb_en && (wb_rd == w_rs1)) ? wb_data : r_rf[w_rs1];
  end

  always_comb begin
    w_rs2_val = '0;
    if (w_rs2 != 5'd0) w_rs2_val = (wb_en && (wb_rd == w_rs2)) ? wb_data : r_rf[w_rs2];
  end

  assign w_ld_hit = r_valid_d && r_ctrl[C_MEM_READ] && (r_rd != 5'd0) &&
                    ((w_uses_rs1 && (w_rs1 == r_rd)) || (w_uses_rs2 && (w_rs2 == r_rd)));

  assign stall_f = !rst && !branch_taken && w_src_valid && w_ld_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
      r_valid_d    <= 1'b0;
      r_pc_d       <= '0;
      r_rs1_val    <= '0;
      r_rs2_val    <= '0;
      r_imm        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_alu_op     <= '0;
      r_funct3     <= '0;
      r_ctrl       <= '0;
    end else if (branch_taken) begin
      r_valid_d    <= 1'b0;
      r_ctrl       <= '0;
      r_hold_valid <= 1'b0;
    end else if (stall_f) begin
      r_hold_valid <= 1'b1;
      r_hold_pc    <= w_src_pc;
      r_hold_instr <= w_src_instr;
      r_valid_d    <= 1'b0;
      r_ctrl       <= '0;
    end else begin
      r_hold_valid <= 1'b0;
      r_valid_d    <= w_src_valid;
      r_ctrl       <= w_src_valid ? w_ctrl : 10'd0;
      r_pc_d       <= w_src_pc;
      r_rs1_val    <= w_rs1_val;
      r_rs2_val    <= w_rs2_val;
      r_imm        <= XLEN'($signed(w_imm32));
      r_rs1        <= w_rs1;
      r_rs2        <= w_rs2;
      r_rd         <= w_rd;
      r_alu_op     <= w_alu_final;
      r_funct3     <= w_f3;
    end
  end

  assign valid_d = r_valid_d;
  assign pc_d    = r_pc_d;
  assign rs1_val = r_rs1_val;
  assign rs2_val = r_rs2_val;
  assign imm     = r_imm;
  assign rs1     = r_rs1;
  assign rs2     = r_rs2;
  assign rd      = r_rd;
  assign alu_op  = r_alu_op;
  assign funct3  = r_funct3;
  assign ctrl    = r_ctrl;

endmodule
